// File: rtl/pulse_rate_meter.sv
// Turbine pulse rate meter: counts debounced pulse edges between 1 Hz gate strobes.
// Define PULSE_RATE_AVG_EN to publish a 4-window moving average instead of the raw count.
module pulse_rate_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MIN_GAP = 4
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iCe,
    input  logic             iTick,
    input  logic             iPulse,
    output logic [CNT_W-1:0] oCount,
    output logic             oValid,
    output logic             oOverflow,
    output logic             oActive
);

    localparam int unsigned GAP_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state;
    logic             sync1, sync2, sync3;
    logic [GAP_W-1:0] gapCnt;
    logic [CNT_W-1:0] acc;
    logic             accOvf;
    logic             winValid;
    logic             risingEdge;
    logic             accept;
    logic [CNT_W-1:0] accInc;

`ifdef PULSE_RATE_AVG_EN
    logic [CNT_W-1:0] histCount [4];
    logic [3:0]       histOvf;
    logic [CNT_W+1:0] histSum;
`endif

    assign risingEdge = sync2 & ~sync3;
    assign accept     = risingEdge && (gapCnt >= GAP_W'(MIN_GAP));
    assign accInc     = (acc == CNT_MAX) ? CNT_MAX : acc + CNT_W'(1);

    // Synchronizer, debounce, window FSM and per-window latch
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state    <= IDLE;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            gapCnt   <= GAP_W'(MIN_GAP);
            acc      <= '0;
            accOvf   <= 1'b0;
            winValid <= 1'b0;
            oActive  <= 1'b0;
`ifdef PULSE_RATE_AVG_EN
            for (int i = 0; i < 4; i++) histCount[i] <= '0;
            histOvf <= '0;
`else
            oCount    <= '0;
            oOverflow <= 1'b0;
`endif
        end else if (!iCe) begin
            winValid <= 1'b0;
        end else begin
            sync1    <= iPulse;
            sync2    <= sync1;
            sync3    <= sync2;
            winValid <= 1'b0;
            oActive  <= (state == COUNT) || iTick;

            if (accept)
                gapCnt <= GAP_W'(1);
            else if (gapCnt < GAP_W'(MIN_GAP))
                gapCnt <= gapCnt + GAP_W'(1);

            case (state)
                IDLE: begin
                    if (iTick) begin
                        state  <= COUNT;
                        acc    <= '0;
                        accOvf <= 1'b0;
                    end
                end
                COUNT: begin
                    if (iTick) begin
                        // An edge accepted on the tick cycle opens the new window
                        winValid <= 1'b1;
                        acc      <= accept ? CNT_W'(1) : '0;
                        accOvf   <= accept && (CNT_W == 1);
`ifdef PULSE_RATE_AVG_EN
                        histCount[0] <= acc;
                        histCount[1] <= histCount[0];
                        histCount[2] <= histCount[1];
                        histCount[3] <= histCount[2];
                        histOvf      <= {histOvf[2:0], accOvf};
`else
                        oCount    <= acc;
                        oOverflow <= accOvf;
`endif
                    end else if (accept) begin
                        acc    <= accInc;
                        accOvf <= accOvf | (accInc == CNT_MAX);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PULSE_RATE_AVG_EN
    always_comb begin
        histSum = (CNT_W+2)'(histCount[0]) + (CNT_W+2)'(histCount[1])
                + (CNT_W+2)'(histCount[2]) + (CNT_W+2)'(histCount[3]);
    end

    // Averaged output stage, one cycle behind the window latch
    always_ff @(posedge iClk) begin
        if (iReset) begin
            oCount    <= '0;
            oOverflow <= 1'b0;
            oValid    <= 1'b0;
        end else if (!iCe) begin
            oValid <= 1'b0;
        end else begin
            oValid <= winValid;
            if (winValid) begin
                oCount    <= CNT_W'(histSum >> 2);
                oOverflow <= |histOvf;
            end
        end
    end
`else
    assign oValid = winValid;
`endif

endmodule
